// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N-channel synchroniser, debounce filter, edge pulses and toggle latch
// Optional auto-repeat of press_pulse: define DEBOUNCE_BANK_REPEAT_EN.
module debounce_bank #(
  parameter int              N_CH          = 4,
  parameter int              CNT_W         = 4,
  parameter int              STABLE_CNT    = 8,
  parameter logic [N_CH-1:0] TOGGLE_MASK   = 4'b0010,
  parameter int              RPT_W         = 8,
  parameter int              REPEAT_DELAY  = 20,
  parameter int              REPEAT_PERIOD = 5
) (
  input  logic            d_clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] toggle_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  if (STABLE_CNT < 1 || STABLE_CNT > (1 << CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > (1 << RPT_W) - 1 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > (1 << RPT_W) - 1) begin : g_bad_param
    $error("debounce_bank: parameter out of legal range");
  end

  logic [N_CH-1:0]  s1, s2;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [N_CH-1:0]  accept, rise, fall, rpt_fire;

  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // A channel accepts its new level on the sample that completes the stable run.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_CH; i++) begin
      accept[i] = (s2[i] != level_out[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = accept & s2;
  assign fall = accept & ~s2;

  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) begin
      level_out <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (s2[i] == level_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level_out[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) begin
      press_pulse   <= '0;
      release_pulse <= '0;
      toggle_out    <= '0;
    end else begin
      press_pulse   <= rise | rpt_fire;
      release_pulse <= fall;
      toggle_out    <= toggle_out ^ (rise & TOGGLE_MASK);
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt [N_CH];
  logic [N_CH-1:0]  rpt_first;

  // A releasing channel never fires, so repeats cannot collide with release_pulse.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      rpt_fire[i] = level_out[i] && !fall[i] &&
                    ((rpt_cnt[i] + RPT_ONE) == (rpt_first[i] ? RPT_DELAY : RPT_PERIOD));
    end
  end

  always_ff @(posedge d_clk or negedge rst) begin
    if (!rst) begin
      rpt_first <= '0;
      for (int i = 0; i < N_CH; i++) begin
        rpt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (rise[i]) begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b1;
        end else if (level_out[i] && !fall[i]) begin
          if (rpt_fire[i]) begin
            rpt_cnt[i]   <= '0;
            rpt_first[i] <= 1'b0;
          end else begin
            rpt_cnt[i] <= rpt_cnt[i] + RPT_ONE;
          end
        end else begin
          rpt_cnt[i]   <= '0;
          rpt_first[i] <= 1'b0;
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank (default parameters)
module tb_debounce_bank;

  logic       d_clk = 1'b0;
  logic       rst   = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic [3:0] level_out, press_pulse, release_pulse, toggle_out;

  debounce_bank dut (
    .d_clk         (d_clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .level_out     (level_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .toggle_out    (toggle_out)
  );

  always #5 d_clk = ~d_clk;

  int cyc = 0;
  always @(posedge d_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] t;
  } ev_t;
  ev_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge d_clk);
    #1;
  endtask

  task automatic exp_ev(input int dc, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] l, input logic [3:0] t);
    ev_t e;
    e.cyc = cyc + dc;
    e.p = p;
    e.r = r;
    e.l = l;
    e.t = t;
    q.push_back(e);
  endtask

  task automatic press_release(input logic [3:0] m, input int hold,
                               input logic [3:0] tog_p, input logic [3:0] tog_r);
    btn_in = m;
    exp_ev(10, m, 4'h0, m, tog_p);
    step(hold);
    btn_in = 4'h0;
    exp_ev(10, 4'h0, m, 4'h0, tog_r);
    step(20);
  endtask

  always @(negedge d_clk) begin
    if (rst && ((press_pulse | release_pulse) != 4'h0)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {press_pulse, release_pulse}, 32'h0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("press_pulse", press_pulse, e.p);
        chk("release_pulse", release_pulse, e.r);
        chk("level_out", level_out, e.l);
        chk("toggle_out", toggle_out, e.t);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d events pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("reset_level", level_out, 4'h0);
    chk("reset_press", press_pulse, 4'h0);
    chk("reset_release", release_pulse, 4'h0);
    chk("reset_toggle", toggle_out, 4'h0);
    step(2);
    rst = 1'b1;
    step(3);

    // clean press on ch0, held 30 cycles
    press_release(4'b0001, 30, 4'b0000, 4'b0000);

    // ch2 bounces with 3-cycle runs, then settles high
    for (int k = 0; k < 14; k++) begin
      btn_in[2] = (k % 2 == 0);
      step(3);
    end
    press_release(4'b0100, 20, 4'b0000, 4'b0000);

    // ch1 is the only toggle channel
    press_release(4'b0011, 20, 4'b0010, 4'b0010);
    press_release(4'b0011, 20, 4'b0000, 4'b0000);
    press_release(4'b0011, 20, 4'b0010, 4'b0010);

    // all channels together
    press_release(4'b1111, 20, 4'b0000, 4'b0000);

    // async reset while the release counter sits at 5
    btn_in = 4'b0011;
    exp_ev(10, 4'b0011, 4'h0, 4'b0011, 4'b0010);
    step(15);
    chk("pre_reset_level", level_out, 4'h3);
    btn_in = 4'h0;
    step(7);
    rst = 1'b0;
    #2;
    chk("async_level", level_out, 4'h0);
    chk("async_press", press_pulse, 4'h0);
    chk("async_release", release_pulse, 4'h0);
    chk("async_toggle", toggle_out, 4'h0);
    step(2);
    rst = 1'b1;
    step(20);
    chk("post_reset_level", level_out, 4'h0);

    // ch3 held: repeats at +20/+25/+30/+35 when enabled
    btn_in = 4'b1000;
    exp_ev(10, 4'b1000, 4'h0, 4'b1000, 4'h0);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    exp_ev(30, 4'b1000, 4'h0, 4'b1000, 4'h0);
    exp_ev(35, 4'b1000, 4'h0, 4'b1000, 4'h0);
    exp_ev(40, 4'b1000, 4'h0, 4'b1000, 4'h0);
    exp_ev(45, 4'b1000, 4'h0, 4'b1000, 4'h0);
`endif
    step(38);
    btn_in = 4'h0;
    exp_ev(10, 4'h0, 4'b1000, 4'h0, 4'h0);
    step(30);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised N-channel button conditioner for the board's push-buttons and switches.
- Per channel: 2-flop synchroniser, stable-count debounce filter, rise/fall one-shot pulses and a per-channel toggle latch.
- Sits between the raw board inputs and the control FSM (clock/stopwatch logic).
- Replaces the fixed 4-input debouncer with a width- and mode-configurable bank.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 4, width of each channel's stability counter.
- STABLE_CNT, 8, consecutive mismatching samples required to accept a new level. Legal range 1..2^CNT_W-1.
- TOGGLE_MASK, 4'b0010, bit i=1 enables the toggle latch on channel i. Width N_CH.
- RPT_W, 8, width of the auto-repeat counter (used only with REPEAT_EN).
- REPEAT_DELAY, 20, cycles from press pulse to first repeat pulse. Legal range 1..2^RPT_W-1.
- REPEAT_PERIOD, 5, cycles between subsequent repeat pulses. Legal range 1..2^RPT_W-1.

Ports:
- d_clk  input  1  debounce sample clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_in  input  N_CH  raw, asynchronous button levels.
- level_out  output  N_CH  debounced level.
- press_pulse  output  N_CH  1-cycle pulse on accepted rise (plus repeats when REPEAT_EN).
- release_pulse  output  N_CH  1-cycle pulse on accepted fall.
- toggle_out  output  N_CH  flips on each genuine press for TOGGLE_MASK channels; constant 0 elsewhere.

Behaviour:
- Reset (rst=0, asynchronous): sync flops, counters, level_out, press_pulse, release_pulse, toggle_out and repeat state all go to 0 immediately.
- Synchroniser: btn_in -> s1 -> s2, one flop per stage per channel. s2 is the filter input.
- Filter, per channel, each edge:
  - s2 == level_out: counter <= 0.
  - s2 != level_out and counter < STABLE_CNT-1: counter <= counter+1.
  - s2 != level_out and counter == STABLE_CNT-1: level_out <= s2 and counter <= 0.
- Latency: an input change held steady changes level_out on the (STABLE_CNT+2)th rising edge after the change.
- Glitch rejection: any mismatch run shorter than STABLE_CNT samples clears the counter; no output changes.
- Pulses:
  - press_pulse is registered; it asserts in the same cycle level_out goes 0->1 and is high for exactly 1 cycle.
  - release_pulse behaves the same for 1->0.
  - Pulses are never both high on one channel in the same cycle.
- Toggle: toggle_out[i] inverts on the edge where level_out[i] goes 0->1, only if TOGGLE_MASK[i]=1. Repeat pulses never toggle.
- Channels are fully independent. Simultaneous transitions on several channels are each processed in the same cycle.
- Button held through reset release: treated as a new press. level_out rises after STABLE_CNT+2 edges with press_pulse; toggle fires if masked.
- Reset mid-count: counter is discarded and no pulse is emitted.
- STABLE_CNT=1: level follows s2 with 1 cycle of filtering (3-edge latency total).

Optional Feature:
- Macro: DEBOUNCE_BANK_REPEAT_EN.
- Defined: while level_out[i]=1, a per-channel repeat counter runs from the press pulse.
  - press_pulse re-asserts REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
  - On release or reset, the counter clears and repeats stop immediately; no repeat pulse coincides with release_pulse.
  - Intended for clock adjust buttons.
- Undefined: repeat counters are not instantiated; exactly one press_pulse per accepted press. RPT_W, REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
- Reset then clean press: btn_in[0] 0->1 held 30 cycles, STABLE_CNT=8 -> level_out[0] rises on edge 10; press_pulse[0] high exactly edge 10; release 10 edges after btn falls, with one release_pulse.
- Bounce rejection: btn_in[2] toggles every 3 cycles for 40 cycles, then settles high -> no pulse during bounce; single press_pulse 10 edges after final settle.
- Toggle mask: 3 presses on ch1 and ch0, TOGGLE_MASK=4'b0010 -> toggle_out[1] sequence 1,0,1; toggle_out[0] stays 0.
- Simultaneous channels: all 4 inputs rise on the same cycle -> press_pulse=4'hF on one cycle; level_out=4'hF.
- Async reset mid-count: assert rst=0 at counter=5 while level_out=4'h3 -> all outputs 0 without a clock edge; no pulse after rst returns 1 with btn_in=0.
- With DEBOUNCE_BANK_REPEAT_EN: hold ch3 for 40 cycles after accept -> press_pulse at +0, +20, +25, +30, +35; none after release; toggle_out[3] unchanged by repeats.
